// File: rtl/cmp_seq_ctrl_if.sv
// rtl/cmp_seq_ctrl_if.sv - request/result bundle between a datapath and cmp_seq_ctrl
//
// Signals:
//   start       request strobe from the datapath
//   a, b        W-bit unsigned operands, captured when start is accepted
//   busy        controller is not idle
//   done        one-cycle pulse, result valid
//   agt/aeq/alt registered result flags (A>B, A==B, A<B)
//
// Modports:
//   master - requesting datapath (drives start/a/b)
//   slave  - cmp_seq_ctrl (drives busy/done/result flags)
interface cmp_seq_ctrl_if #(
  parameter int W = 16
) ();

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         agt;
  logic         aeq;
  logic         alt;

  modport master (
    output start, a, b,
    input  busy, done, agt, aeq, alt
  );

  modport slave (
    input  start, a, b,
    output busy, done, agt, aeq, alt
  );

endinterface

// File: rtl/cmp_seq_ctrl.sv
// rtl/cmp_seq_ctrl.sv - wide unsigned compare by time-multiplexing one N-bit cascaded comparator
//
// agtb_n: N-bit magnitude comparator slice with cascade inputs.
//   a, b          N-bit chunk operands
//   agtbi, aeqbi  flags from the more significant chunks
//   agtbo, aeqbo  flags including this chunk
//
// cmp_seq_ctrl: walks the operands MSB chunk first, one chunk per cycle,
// stopping at the first unequal chunk.
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   cmp_seq_ctrl_if slave (start/a/b in; busy/done/agt/aeq/alt out)
module agtb_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         agtbi,
  input  logic         aeqbi,
  output logic         agtbo,
  output logic         aeqbo
);

  // A more significant chunk that already decided "greater" wins; this
  // chunk only matters while everything above it was equal.
  assign agtbo = agtbi | (aeqbi & (a > b));
  assign aeqbo = aeqbi & (a == b);

endmodule

module cmp_seq_ctrl #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  cmp_seq_ctrl_if.slave  bus
);

  localparam int C  = W / N;
  localparam int IW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [IW-1:0] idx;
  logic          gt_p;
  logic          eq_p;

  logic          busy_r;
  logic          done_r;
  logic          agt_r;
  logic          aeq_r;
  logic          alt_r;

  logic [N-1:0]  slice_a;
  logic [N-1:0]  slice_b;
  logic          slice_gt;
  logic          slice_eq;

  // Chunk select as an explicit mux so only valid chunk positions are
  // reachable even when C is not a power of two.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < C; i++) begin
      if (idx == IW'(i)) begin
        slice_a = a_r[i*N +: N];
        slice_b = b_r[i*N +: N];
      end
    end
  end

  agtb_n #(.N(N)) u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .agtbi (gt_p),
    .aeqbi (eq_p),
    .agtbo (slice_gt),
    .aeqbo (slice_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      idx    <= '0;
      gt_p   <= 1'b0;
      eq_p   <= 1'b1;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      agt_r  <= 1'b0;
      aeq_r  <= 1'b0;
      alt_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= bus.b;
            idx    <= IW'(C - 1);
            gt_p   <= 1'b0;
            eq_p   <= 1'b1;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          gt_p <= slice_gt;
          eq_p <= slice_eq;
          // Once a chunk differs, lower chunks cannot change the outcome.
          if (idx == '0 || !slice_eq) begin
            agt_r  <= slice_gt;
            aeq_r  <= slice_eq;
            alt_r  <= ~slice_gt & ~slice_eq;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end

        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.agt  = agt_r;
  assign bus.aeq  = aeq_r;
  assign bus.alt  = alt_r;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// tb/tb_cmp_seq_ctrl.sv - directed self-checking bench for cmp_seq_ctrl
module tb_cmp_seq_ctrl;

  localparam int W = 16;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  cmp_seq_ctrl_if #(.W(W)) bus ();

  cmp_seq_ctrl #(.W(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the accepting edge until done is seen.
  // With inject set, a second start with different operands is pulsed
  // mid-RUN and must be ignored.
  task automatic wait_done(input bit inject, output int n);
    n = 0;
    while (!bus.done && n < 20) begin
      step();
      n++;
      if (inject && n == 1) begin
        bus.start = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'h0000;
      end else if (inject && n == 2) begin
        bus.start = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'hFFFF;
      end
    end
  endtask

  task automatic run_cmp(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input bit inject, input int exp_k,
                         input bit egt, input bit eeq, input bit elt);
    int n;
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    step();
    bus.start = 1'b0;
    check({tag, "_busy_run"}, {31'd0, bus.busy}, 32'd1);
    wait_done(inject, n);
    check({tag, "_latency"}, n, exp_k);
    check({tag, "_agt"}, {31'd0, bus.agt}, {31'd0, egt});
    check({tag, "_aeq"}, {31'd0, bus.aeq}, {31'd0, eeq});
    check({tag, "_alt"}, {31'd0, bus.alt}, {31'd0, elt});
    step();
    check({tag, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done_after"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int n;
    int seen_done;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) step();
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_agt",  {31'd0, bus.agt},  32'd0);
    check("rst_aeq",  {31'd0, bus.aeq},  32'd0);
    check("rst_alt",  {31'd0, bus.alt},  32'd0);
    rst = 1'b0;
    step();

    run_cmp("eq",   16'h1234, 16'h1234, 1'b0, 4, 1'b0, 1'b1, 1'b0);
    run_cmp("msb",  16'h8000, 16'h7FFF, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    run_cmp("mid",  16'h12F4, 16'h1304, 1'b0, 2, 1'b0, 1'b0, 1'b1);
    run_cmp("busy", 16'h0001, 16'h0000, 1'b1, 4, 1'b1, 1'b0, 1'b0);

    // Abort mid-RUN: reset clears everything and no done follows.
    bus.start = 1'b1;
    bus.a     = 16'h0001;
    bus.b     = 16'h0000;
    step();
    bus.start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_agt",  {31'd0, bus.agt},  32'd0);
    check("abort_aeq",  {31'd0, bus.aeq},  32'd0);
    check("abort_alt",  {31'd0, bus.alt},  32'd0);
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.done) seen_done++;
    end
    check("abort_no_done", seen_done, 0);
    run_cmp("after_abort", 16'h0001, 16'h0000, 1'b0, 4, 1'b1, 1'b0, 1'b0);

    // Back-to-back with start held high.
    bus.start = 1'b1;
    bus.a     = 16'h00FF;
    bus.b     = 16'h00FF;
    step();
    wait_done(1'b0, n);
    check("b2b1_latency", n, 4);
    check("b2b1_aeq", {31'd0, bus.aeq}, 32'd1);
    bus.a = 16'h0000;
    bus.b = 16'h0100;
    step();
    check("b2b_idle_busy", {31'd0, bus.busy}, 32'd0);
    check("b2b_idle_done", {31'd0, bus.done}, 32'd0);
    check("b2b_idle_aeq",  {31'd0, bus.aeq},  32'd1);
    step();
    bus.start = 1'b0;
    check("b2b2_accept_busy", {31'd0, bus.busy}, 32'd1);
    check("b2b2_run_aeq",     {31'd0, bus.aeq},  32'd1);
    check("b2b2_run_alt",     {31'd0, bus.alt},  32'd0);
    wait_done(1'b0, n);
    check("b2b2_latency", n, 2);
    check("b2b2_alt", {31'd0, bus.alt}, 32'd1);
    check("b2b2_agt", {31'd0, bus.agt}, 32'd0);
    check("b2b2_aeq", {31'd0, bus.aeq}, 32'd0);
    step();
    check("b2b2_hold_alt", {31'd0, bus.alt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
